// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: m_count masters share one slave port.
// The grant is held for the whole cyc burst; a per-strobe watchdog terminates
// stalled accesses with err so a dead slave cannot hang a master.
module wb_rr_arbiter #(
   parameter int unsigned m_count        = 2,
   parameter int unsigned adr_width      = 32,
   parameter int unsigned dat_width      = 32,
   parameter int unsigned sel_width      = dat_width / 8,
   parameter int unsigned timeout_cycles = 255
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [m_count-1:0]             m_cyc,
   input  logic [m_count-1:0]             m_stb,
   input  logic [m_count-1:0]             m_we,
   input  logic [m_count*adr_width-1:0]   m_adr,
   input  logic [m_count*dat_width-1:0]   m_dat_w,
   input  logic [m_count*sel_width-1:0]   m_sel,
   output logic [m_count-1:0]             m_ack,
   output logic [m_count-1:0]             m_err,
   output logic [dat_width-1:0]           m_dat_r,
   output logic                           s_cyc,
   output logic                           s_stb,
   output logic                           s_we,
   output logic [adr_width-1:0]           s_adr,
   output logic [dat_width-1:0]           s_dat_w,
   output logic [sel_width-1:0]           s_sel,
   input  logic                           s_ack,
   input  logic                           s_err,
   input  logic [dat_width-1:0]           s_dat_r,
   output logic [m_count-1:0]             grant
);

   localparam int unsigned IW = (m_count > 1) ? $clog2(m_count) : 1;
   localparam int unsigned WW = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [m_count-1:0]   grant_q, grant_d;
   logic [IW-1:0]        last_q, last_d;
   logic [WW-1:0]        wd_q, wd_d;

   logic                 busy;
   logic                 own_cyc, own_stb, own_we;
   logic [adr_width-1:0] own_adr;
   logic [dat_width-1:0] own_dat;
   logic [sel_width-1:0] own_sel;
   logic                 stalled, expire;

   assign busy = (state_q == BUSY);

   // Select the owning master's signals; last_q doubles as the owner index while busy
   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      own_we  = 1'b0;
      own_adr = '0;
      own_dat = '0;
      own_sel = '0;
      for (int unsigned i = 0; i < m_count; i++) begin
         if (last_q == IW'(i)) begin
            own_cyc = m_cyc[i];
            own_stb = m_stb[i];
            own_we  = m_we[i];
            own_adr = m_adr[i*adr_width +: adr_width];
            own_dat = m_dat_w[i*dat_width +: dat_width];
            own_sel = m_sel[i*sel_width +: sel_width];
         end
      end
   end

   // Watchdog: a strobe that has waited timeout_cycles cycles is terminated with err;
   // a coinciding slave ack suppresses the expiry
   assign stalled = busy & own_cyc & own_stb & ~s_ack & ~s_err;
   assign expire  = (timeout_cycles != 0) && stalled &&
                    (wd_q == WW'(timeout_cycles - 1));

   // Slave-side mux, forced quiet while idle and stb withheld on the expiry cycle
   always_comb begin
      s_cyc   = busy & own_cyc;
      s_stb   = busy & own_stb & ~expire;
      s_we    = busy & own_we;
      s_adr   = busy ? own_adr : '0;
      s_dat_w = busy ? own_dat : '0;
      s_sel   = busy ? own_sel : '0;
      m_ack   = (busy & s_ack) ? grant_q : '0;
      m_err   = (busy & (s_err | expire)) ? grant_q : '0;
   end

   assign m_dat_r = s_dat_r;
   assign grant   = grant_q;

   // Arbitration, release and watchdog next-state
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      if (state_q == IDLE) begin
         // Scan last+1, last+2, ... so the most recent owner has lowest priority
         for (int unsigned off = 1; off <= m_count; off++) begin
            for (int unsigned j = 0; j < m_count; j++) begin
               if ((state_d == IDLE) && (j == (32'(last_q) + off) % m_count) && m_cyc[j]) begin
                  state_d    = BUSY;
                  grant_d    = '0;
                  grant_d[j] = 1'b1;
                  last_d     = IW'(j);
               end
            end
         end
      end else if (!own_cyc) begin
         state_d = IDLE;
         grant_d = '0;
      end
      if ((timeout_cycles == 0) || !stalled || expire) begin
         wd_d = '0;
      end else begin
         wd_d = wd_q + WW'(1);
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(m_count - 1);
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus randomized
// traffic compared each cycle against a behavioural owner/priority model.
module tb_wb_rr_arbiter;

   localparam int M  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [M-1:0]      m_cyc = '0, m_stb = '0, m_we = '0;
   logic [M*AW-1:0]   m_adr = '0;
   logic [M*DW-1:0]   m_dat_w = '0;
   logic [M*SW-1:0]   m_sel = '0;
   logic [M-1:0]      m_ack, m_err, grant;
   logic [DW-1:0]     m_dat_r;
   logic              s_cyc, s_stb, s_we;
   logic [AW-1:0]     s_adr;
   logic [DW-1:0]     s_dat_w;
   logic [SW-1:0]     s_sel;
   logic              s_ack = 1'b0, s_err = 1'b0;
   logic [DW-1:0]     s_dat_r = '0;

   wb_rr_arbiter #(
      .m_count(M), .adr_width(AW), .dat_width(DW), .sel_width(SW), .timeout_cycles(TO)
   ) dut (
      .clock(clock), .reset(reset),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
      .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
      .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
      .grant(grant)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Master stimulus state
   bit          cyc_a [M];
   bit          stb_a [M];
   bit          we_a  [M];
   logic [31:0] adr_a [M];
   logic [31:0] dat_a [M];
   logic [3:0]  sel_a [M];
   int          left_a[M];
   bit          term_prev[M];

   // Reference model: current owner (-1 idle), last winner, stalled-strobe count
   int mdl_owner, mdl_last, mdl_wd;

   // Observations captured at the checking edge
   logic [M-1:0] obs_mack, obs_merr, obs_grant, prev_grant;
   logic         obs_sstb;
   int           ack0_cnt;
   int           order_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < M; i++) begin
         m_cyc[i] = cyc_a[i];
         m_stb[i] = stb_a[i];
         m_we[i]  = we_a[i];
         m_adr[i*AW +: AW]   = adr_a[i];
         m_dat_w[i*DW +: DW] = dat_a[i];
         m_sel[i*SW +: SW]   = sel_a[i];
      end
   endtask

   task automatic model_reset();
      mdl_owner = -1;
      mdl_last  = M - 1;
      mdl_wd    = 0;
      prev_grant = '0;
      for (int i = 0; i < M; i++) term_prev[i] = 1'b0;
   endtask

   task automatic clear_masters();
      for (int i = 0; i < M; i++) begin
         cyc_a[i] = 0; stb_a[i] = 0; we_a[i] = 0;
         adr_a[i] = '0; dat_a[i] = '0; sel_a[i] = '0; left_a[i] = 0;
      end
      s_ack = 1'b0;
      s_err = 1'b0;
   endtask

   task automatic new_xfer(input int i);
      adr_a[i] = $urandom;
      dat_a[i] = $urandom;
      sel_a[i] = 4'($urandom);
      we_a[i]  = 1'($urandom);
   endtask

   // Called at posedge+1 with inputs staged; checks at negedge, advances the model
   task automatic cycle();
      logic [M-1:0] e_grant, e_ack, e_err;
      logic         e_scyc, e_sstb, e_swe;
      logic [31:0]  e_sadr, e_sdat;
      logic [3:0]   e_ssel;
      bit           stalled, expire, found;
      int           o, c;
      pack();
      @(negedge clock);
      o = mdl_owner;
      e_grant = '0; e_ack = '0; e_err = '0;
      e_scyc = 0; e_sstb = 0; e_swe = 0; e_sadr = '0; e_sdat = '0; e_ssel = '0;
      stalled = 0; expire = 0;
      if (o >= 0) begin
         stalled = cyc_a[o] && stb_a[o] && !s_ack && !s_err;
         expire  = stalled && (mdl_wd == TO - 1);
         e_grant = M'(1) << o;
         e_scyc  = cyc_a[o];
         e_sstb  = stb_a[o] && !expire;
         e_swe   = we_a[o];
         e_sadr  = adr_a[o];
         e_sdat  = dat_a[o];
         e_ssel  = sel_a[o];
         if (s_ack) e_ack = M'(1) << o;
         if (s_err || expire) e_err = M'(1) << o;
      end
      check("grant",   64'(grant),   64'(e_grant));
      check("s_cyc",   64'(s_cyc),   64'(e_scyc));
      check("s_stb",   64'(s_stb),   64'(e_sstb));
      check("s_we",    64'(s_we),    64'(e_swe));
      check("s_adr",   64'(s_adr),   64'(e_sadr));
      check("s_dat_w", 64'(s_dat_w), 64'(e_sdat));
      check("s_sel",   64'(s_sel),   64'(e_ssel));
      check("m_ack",   64'(m_ack),   64'(e_ack));
      check("m_err",   64'(m_err),   64'(e_err));
      check("m_dat_r", 64'(m_dat_r), 64'(s_dat_r));
      obs_mack = m_ack; obs_merr = m_err; obs_grant = grant; obs_sstb = s_stb;
      if (m_ack[0]) ack0_cnt++;
      if (prev_grant == '0 && grant != '0)
         for (int k = 0; k < M; k++) if (grant[k]) order_q.push_back(k);
      prev_grant = grant;
      for (int i = 0; i < M; i++) term_prev[i] = e_ack[i] | e_err[i];
      if (o < 0) begin
         found = 0;
         for (int k = 1; k <= M; k++) begin
            c = (mdl_last + k) % M;
            if (!found && cyc_a[c]) begin
               found = 1; mdl_owner = c; mdl_last = c;
            end
         end
         mdl_wd = 0;
      end else if (!cyc_a[o]) begin
         mdl_owner = -1;
         mdl_wd = 0;
      end else begin
         mdl_wd = (stalled && !expire) ? mdl_wd + 1 : 0;
      end
      @(posedge clock);
      #1;
   endtask

   // Synchronous-looking reset pulse; leaves the bench at posedge+1
   task automatic reset_dut();
      reset = 1'b0;
      clear_masters();
      pack();
      @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic run_random(input int ncyc, input bit [M-1:0] mask, input int p_req,
                             input int p_ack, input int p_err, input int p_abort);
      int o;
      for (int n = 0; n < ncyc; n++) begin
         for (int i = 0; i < M; i++) begin
            if (cyc_a[i]) begin
               if (term_prev[i]) begin
                  left_a[i]--;
                  if (left_a[i] <= 0) begin
                     cyc_a[i] = 0; stb_a[i] = 0;
                  end else begin
                     new_xfer(i);
                     stb_a[i] = ($urandom % 4) != 0;
                  end
               end else if (!stb_a[i]) begin
                  stb_a[i] = 1;
               end else if (int'($urandom % 100) < p_abort) begin
                  cyc_a[i] = 0; stb_a[i] = 0;
               end
            end else if (mask[i] && int'($urandom % 100) < p_req) begin
               cyc_a[i] = 1; stb_a[i] = 1;
               left_a[i] = int'($urandom_range(1, 3));
               new_xfer(i);
            end
         end
         o = mdl_owner;
         s_ack = 0; s_err = 0;
         if (o >= 0 && cyc_a[o] && stb_a[o]) begin
            if (int'($urandom % 100) < p_ack) s_ack = 1;
            else if (int'($urandom % 100) < p_err) s_err = 1;
         end else if (o < 0 && ($urandom % 100) < 5) begin
            s_ack = 1;  // stray late ack while idle must not reach any master
         end
         s_dat_r = $urandom;
         cycle();
      end
   endtask

   int err_at;
   logic stb_at_err;

   initial begin
      clear_masters();
      model_reset();
      pack();
      #1 reset = 1'b0;
      #1;
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_s_cyc", 64'({s_cyc, s_stb, s_we}), 64'(0));
      check("rst_s_adr", 64'(s_adr), 64'(0));
      check("rst_m_ack", 64'({m_ack, m_err}), 64'(0));
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Single master write, slave acks two cycles after the strobe
      reset_dut();
      ack0_cnt = 0;
      cyc_a[0] = 1; stb_a[0] = 1; we_a[0] = 1;
      adr_a[0] = 32'h10; dat_a[0] = 32'hDEADBEEF; sel_a[0] = 4'hF;
      cycle();
      check("d1_decide_grant", 64'(obs_grant), 64'(0));
      cycle();
      check("d1_grant", 64'(obs_grant), 64'(1));
      check("d1_s_adr", 64'(s_adr), 64'(32'h10));
      cycle();
      s_ack = 1;
      cycle();
      s_ack = 0; cyc_a[0] = 0; stb_a[0] = 0;
      cycle();
      check("d1_release_grant", 64'(obs_grant), 64'(1));
      cycle();
      check("d1_idle_grant", 64'(obs_grant), 64'(0));
      check("d1_ack_pulses", 64'(ack0_cnt), 64'(1));

      // Two masters from reset: alternate 0,1,0,1
      reset_dut();
      order_q.delete();
      run_random(40, 3'b011, 100, 100, 0, 0);
      check("d2_bursts", 64'(order_q.size() >= 4), 64'(1));
      for (int k = 0; k < 4 && k < order_q.size(); k++)
         check("d2_order", 64'(order_q[k]), 64'(k % 2));

      // Three masters: 0,1,2,0,1,2
      reset_dut();
      order_q.delete();
      run_random(60, 3'b111, 100, 100, 0, 0);
      check("d3_bursts", 64'(order_q.size() >= 6), 64'(1));
      for (int k = 0; k < 6 && k < order_q.size(); k++)
         check("d3_order", 64'(order_q[k]), 64'(k % 3));

      // Watchdog expiry with a dead slave; master 1 waits behind master 0
      reset_dut();
      ack0_cnt = 0;
      err_at = -1; stb_at_err = 1'b1;
      cyc_a[0] = 1; stb_a[0] = 1; adr_a[0] = 32'h40;
      cyc_a[1] = 1; stb_a[1] = 1; adr_a[1] = 32'h80;
      cycle();
      for (int n = 1; n <= 7; n++) begin
         cycle();
         if (err_at < 0 && obs_merr[0]) begin
            err_at = n; stb_at_err = obs_sstb;
            cyc_a[0] = 0; stb_a[0] = 0;
         end
      end
      check("d4_err_cycle", 64'(err_at), 64'(TO));
      check("d4_stb_at_err", 64'(stb_at_err), 64'(0));
      check("d4_no_ack", 64'(ack0_cnt), 64'(0));
      check("d4_next_owner", 64'(obs_grant), 64'(3'b010));

      // Ack on the expiry cycle wins over the watchdog
      reset_dut();
      cyc_a[0] = 1; stb_a[0] = 1; adr_a[0] = 32'h44;
      cycle();
      for (int n = 0; n < TO - 1; n++) cycle();
      s_ack = 1;
      cycle();
      check("d5_ack", 64'(obs_mack), 64'(3'b001));
      check("d5_err", 64'(obs_merr), 64'(0));
      s_ack = 0; cyc_a[0] = 0; stb_a[0] = 0;
      cycle();
      cycle();

      // Randomized traffic: healthy slave, dead slave, slow slave
      reset_dut();
      run_random(400, 3'b111, 40, 40, 5, 3);
      run_random(200, 3'b111, 50, 0, 0, 2);
      run_random(300, 3'b111, 50, 20, 3, 2);

      // Asynchronous reset mid-burst
      reset_dut();
      cyc_a[0] = 1; stb_a[0] = 1; adr_a[0] = 32'h1234;
      cycle();
      cycle();
      check("d6_pre_s_cyc", 64'(s_cyc), 64'(1));
      #2 reset = 1'b0;
      #1;
      check("d6_async_s_cyc", 64'({s_cyc, s_stb}), 64'(0));
      check("d6_async_grant", 64'(grant), 64'(0));
      check("d6_async_s_adr", 64'(s_adr), 64'(0));
      @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();
      clear_masters();
      cyc_a[1] = 1; stb_a[1] = 1; adr_a[1] = 32'h5678;
      cycle();
      cycle();
      check("d6_regrant", 64'(obs_grant), 64'(3'b010));
      cyc_a[1] = 0; stb_a[1] = 0;
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin arbiter that shares one Wishbone classic slave port among m_count Wishbone masters, e.g. CPU instruction and data ports plus a debug/DMA master in front of the xbar or UART. It locks the grant for the whole cyc burst. A per-transfer watchdog terminates stalled slave accesses with err, so a dead slave cannot hang the system.

Parameters:
m_count, 2, number of masters (2..8)
adr_width, 32, address width
dat_width, 32, data width
sel_width, dat_width/8, byte-select width
timeout_cycles, 255, stalled-stb cycles before watchdog err (>=2; 0 disables the watchdog)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
m_cyc  in  m_count  per-master cyc
m_stb  in  m_count  per-master stb
m_we  in  m_count  per-master we
m_adr  in  m_count*adr_width  packed addresses, master i at [i*adr_width +: adr_width]
m_dat_w  in  m_count*dat_width  packed write data
m_sel  in  m_count*sel_width  packed byte selects
m_ack  out  m_count  ack routed to the granted master only
m_err  out  m_count  err routed to the granted master only (slave err or watchdog)
m_dat_r  out  dat_width  slave read data, broadcast to all masters
s_cyc, s_stb, s_we  out  1  slave control
s_adr  out  adr_width  slave address
s_dat_w  out  dat_width  slave write data
s_sel  out  sel_width  slave byte selects
s_ack, s_err  in  1  slave termination
s_dat_r  in  dat_width  slave read data
grant  out  m_count  one-hot current owner, 0 when idle

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, last=m_count-1, watchdog count=0. Outputs s_cyc/s_stb/s_we=0, s_adr/s_dat_w/s_sel=0, m_ack/m_err=0.
- FSM IDLE: if any m_cyc, choose the first requester scanning last+1, last+2, ... modulo m_count. Register grant and set last=winner, then go to BUSY. Arbitration costs 1 cycle; the slave sees nothing in the decision cycle.
- FSM BUSY: slave outputs are a combinational mux of the granted master's cyc/stb/we/adr/dat_w/sel. s_ack/s_err go only to the granted bit of m_ack/m_err; other bits are 0. Other masters' requests are ignored.
- Release: when m_cyc[granted]=0 in BUSY, the next state is IDLE and grant clears. s_cyc follows the master, so it drops the same cycle. No same-cycle regrant: there is at least 1 idle cycle between owners, and a re-request needs a fresh arbitration.
- Round-robin fairness: with all masters requesting continuously, grants rotate 0,1,..,m_count-1,0. No master waits more than m_count-1 bursts.
- Watchdog: the counter increments each BUSY cycle with s_stb=1 and s_ack=0 and s_err=0. It clears on ack, err, stb=0 or IDLE.
- Watchdog expiry: when count reaches timeout_cycles, m_err[granted] pulses for exactly 1 cycle. s_stb is forced to 0 that cycle and the counter clears. The grant is kept until the master drops cyc.
- Watchdog collision: if s_ack and expiry coincide, ack wins, there is no err, and the counter clears.
- Pipelined masters: a master holding cyc with consecutive stbs keeps the grant. Each stb gets its own watchdog window.
- Requester abort: if the granted master drops cyc mid-transfer, the arbiter goes to IDLE and a late s_ack is discarded (m_ack=0).
- Reset mid-burst: all outputs return to reset values immediately and asynchronously. After reset, master 0 has top priority.
- m_count=1 degenerates to a registered grant plus the watchdog.

Test Plan:
- Single master 0 writes adr 0x10 dat 0xDEADBEEF sel 0xF; slave acks 2 cycles after stb -> grant=01 one cycle after cyc, s_adr=0x10, m_ack[0] pulses once, grant=00 the cycle after cyc drops.
- Masters 0 and 1 assert cyc in the same cycle after reset -> master 0 is granted first, then master 1 after 1 idle cycle. Repeat continuously -> grants alternate 0,1,0,1.
- m_count=3, all requesting for 6 bursts -> grant order 0,1,2,0,1,2 and no starvation.
- timeout_cycles=4, slave never acks -> m_err[granted] pulses on the 4th stalled cycle with s_stb=0 that cycle; m_ack stays 0; the other master is granted after the owner drops cyc.
- Slave acks on exactly the expiry cycle -> m_ack=1 and m_err=0.
- Assert reset low mid-burst -> s_cyc=0 and grant=0 asynchronously; after release, a master 1 request is granted normally.
